data_sram_bridge: RTL

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

---
 rtl/data_sram_bridge.sv | 127 ++++++++++++
 1 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Bridges a CPU-style data request port (req/addr_ok/data_ok) onto a
//   memory port that has separate request and response handshakes.
//   At most one transaction is in flight. The request fields are captured
//   when the request is accepted and are held until the memory takes them.
//
// Ports
//   clk, reset            : clock and synchronous active-high reset
//   req, wr, wstrb,
//   addr, wdata           : CPU request (accepted when addr_ok=1)
//   addr_ok               : high while idle; a req seen then is accepted
//   data_ok, rdata        : one-cycle completion pulse and read data
//   m_req_valid/ready     : memory request handshake
//   m_req_wr/addr/
//   wstrb/wdata           : captured request fields
//   m_resp_valid/rdata    : memory response (one per request)
//
// State table
//   IDLE | no transaction; addr_ok=1, capture on req
//   REQ  | request presented to memory, waiting for m_req_ready
//   RESP | request taken by memory, waiting for m_resp_valid

module data_sram_bridge #(
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic        m_req_wr,
  output logic [31:0] m_req_addr,
  output logic [3:0]  m_req_wstrb,
  output logic [31:0] m_req_wdata,
  input  logic        m_resp_valid,
  input  logic [31:0] m_resp_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        m_req_valid_q, m_req_valid_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_REQ;
          wr_d    = wr;
          addr_d  = ALIGN_ADDR ? {addr[31:2], 2'b00} : addr;
          // Reads never carry byte enables to the memory.
          wstrb_d = wr ? wstrb : 4'b0000;
          wdata_d = wdata;
        end
      end
      ST_REQ: begin
        if (m_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (m_resp_valid) begin
          state_d   = ST_IDLE;
          data_ok_d = 1'b1;
          // Write responses leave the last read data visible.
          if (!wr_q) rdata_d = m_resp_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    m_req_valid_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      m_req_valid_q <= 1'b0;
      data_ok_q     <= 1'b0;
      rdata_q       <= 32'h0;
      wr_q          <= 1'b0;
      addr_q        <= 32'h0;
      wstrb_q       <= 4'h0;
      wdata_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      m_req_valid_q <= m_req_valid_d;
      data_ok_q     <= data_ok_d;
      rdata_q       <= rdata_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wstrb_q       <= wstrb_d;
      wdata_q       <= wdata_d;
    end
  end

  assign addr_ok     = (state_q == ST_IDLE);
  assign data_ok     = data_ok_q;
  assign rdata       = rdata_q;
  assign m_req_valid = m_req_valid_q;
  assign m_req_wr    = wr_q;
  assign m_req_addr  = addr_q;
  assign m_req_wstrb = wstrb_q;
  assign m_req_wdata = wdata_q;

endmodule
